ram_nwmr_lvt: RTL and testbench
===============================

# ram_nwmr_lvt

Parametrised multi-port RAM with NUM_WR write ports and NUM_RD read ports, built from banked 1-write/1-read arrays and a live-value table (LVT) that records which write port last wrote each address. It is the general successor to the fixed 2-write/4-read replicated memory. It adds a reset-time zeroing sweep, defined write-conflict priority, selectable read-during-write bypass and out-of-range protection. It sits under register files, scoreboards and queue state in the core.

## Interface
- RAM_TYPE, 0, bank implementation selector, passed to every bank
- RAM_DEPTH, 64, number of entries
- RAM_ADDR_WIDTH, 6, address width; must satisfy 2^RAM_ADDR_WIDTH >= RAM_DEPTH
- RAM_DATA_WIDTH, 32, data width
- NUM_WR, 2, write ports (1..4)
- NUM_RD, 4, read ports (1..8)
- WR_BYPASS, 1, 1 = read-during-write returns new data; 0 = old data
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- r_val  in  NUM_RD  per-port read request
- r_addr  in  NUM_RD*RAM_ADDR_WIDTH  packed read addresses, port i at slice i
- r_data  out  NUM_RD*RAM_DATA_WIDTH  packed read data, registered
- w_val  in  NUM_WR  per-port write enable
- w_addr  in  NUM_WR*RAM_ADDR_WIDTH  packed write addresses
- w_data  in  NUM_WR*RAM_DATA_WIDTH  packed write data
- init_done  out  1  high once the zeroing sweep completes

## Operation
- Storage: NUM_WR x NUM_RD banks. Bank[w][r] is written only by write port w and read only by read port r.
- LVT: RAM_DEPTH entries of max(1,clog2(NUM_WR)) bits, held in flops. On a write by port w, LVT[addr] <= w.
- Read: read port r selects bank[LVT[addr]][r].
- FSM states: INIT and READY.
  - Reset enters INIT with the sweep counter at 0.
  - INIT writes zero to address cnt in all banks and sets LVT[cnt]=0, one address per cycle. It moves to READY after address RAM_DEPTH-1.
- During INIT:
  - w_val is ignored.
  - Reads return 0.
  - init_done=0.
- Write conflict: when several ports write the same address in one cycle, the highest-index port wins. All enabled banks are written, but the LVT records the highest index.
- Read-during-write, same address, same cycle:
  - WR_BYPASS=1: the read returns the winning write data.
  - WR_BYPASS=0: the read returns the prior contents.
- Address >= RAM_DEPTH: the write is dropped (no bank or LVT update) and the read returns 0.
- When r_val is low, r_data[port] holds its previous value.

## Timing
- Reset values: r_data=0, init_done=0, FSM=INIT, sweep counter=0.
- init_done rises at the rising edge RAM_DEPTH cycles after the first edge with rst_n high.
- Read latency is 1: r_addr sampled at edge N gives r_data valid after edge N.
- A write at edge N is visible to a read sampled at edge N+1. It is also visible at edge N when WR_BYPASS=1.
- Asserting rst_n low mid-operation:
  - Outputs clear immediately and the FSM returns to INIT.
  - The full sweep reruns; no prior contents survive.
- The LVT is internal flops, so the only critical path is LVT lookup plus the NUM_WR:1 mux plus the bypass compare. No further pipeline stage is added.

## Structure
- Package ram_pkg holds:
  - RAM_TYPE encodings,
  - a clog2-based LVT width function,
  - the state enum {INIT, READY}.
- Sub-module ram_1w1r is one bank (1 write, 1 read, registered read). It is instantiated NUM_WR*NUM_RD times in a generate loop.
- The top level owns the FSM, sweep counter, LVT, bypass compare, range check and output muxes.

## Test plan
- Reset, then wait RAM_DEPTH=64 cycles. Required: init_done rises exactly at cycle 64, and all 4 ports reading addresses 0..63 return 0.
- w0 writes 0xAAAA_0001 to address 5, then w1 writes 0xBBBB_0002 to address 5 one cycle later. Required: a read of address 5 on every port returns 0xBBBB_0002.
- w0 and w1 both write address 9 in the same cycle, with 0x11 and 0x22. Required: every read port returns 0x22.
- Read-during-write with address 3 holding 0x5 and a new write of 0x7 in the same cycle:
  - WR_BYPASS=1: r_data=0x7.
  - WR_BYPASS=0: r_data=0x5, then 0x7 on the next read.
- Write 0xDEAD to address 70 (out of range for DEPTH=64). Required: no update; a read of address 70 returns 0; address 6 is unchanged.
- Write 0x1234 to address 2, assert rst_n low mid-sweep and mid-traffic, then release. Required: r_data=0 and init_done=0 immediately; after the sweep, address 2 reads 0.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the LVT multi-port RAM: bank style
// encodings, the state enum and the LVT/index width helper.
package ram_pkg;

    localparam int RAM_TYPE_AUTO  = 0;
    localparam int RAM_TYPE_BLOCK = 1;
    localparam int RAM_TYPE_DIST  = 2;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    // Width needed to name one of n items, never below one bit.
    function automatic int lvt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ram_1w1r.sv
// One storage bank: single write port, single registered read port.
// Ports: clk, we/waddr/wdata (write), re/raddr (read), rdata (registered).
module ram_1w1r
    import ram_pkg::*;
#(
    parameter int RAM_TYPE   = 0,
    parameter int RAM_DEPTH  = 64,
    parameter int IDX_WIDTH  = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [IDX_WIDTH-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    generate
        if (RAM_TYPE == RAM_TYPE_BLOCK) begin : g_block
            (* ram_style = "block" *)
            logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

            // Read-first: a same-address write is not seen this edge.
            always_ff @(posedge clk) begin
                if (we) mem[waddr] <= wdata;
                if (re) rdata <= mem[raddr];
            end
        end else begin : g_dist
            logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

            always_ff @(posedge clk) begin
                if (we) mem[waddr] <= wdata;
                if (re) rdata <= mem[raddr];
            end
        end
    endgenerate

endmodule

// File: rtl/ram_nwmr_lvt.sv
// NUM_WR-write / NUM_RD-read RAM from 1w1r banks plus a live-value table.
// Ports: clk, rst_n, r_val/r_addr -> r_data (1-cycle), w_val/w_addr/w_data, init_done.
module ram_nwmr_lvt
    import ram_pkg::*;
#(
    parameter int RAM_TYPE       = 0,
    parameter int RAM_DEPTH      = 64,
    parameter int RAM_ADDR_WIDTH = 6,
    parameter int RAM_DATA_WIDTH = 32,
    parameter int NUM_WR         = 2,
    parameter int NUM_RD         = 4,
    parameter int WR_BYPASS      = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_RD-1:0]                  r_val,
    input  logic [NUM_RD*RAM_ADDR_WIDTH-1:0]   r_addr,
    output logic [NUM_RD*RAM_DATA_WIDTH-1:0]   r_data,
    input  logic [NUM_WR-1:0]                  w_val,
    input  logic [NUM_WR*RAM_ADDR_WIDTH-1:0]   w_addr,
    input  logic [NUM_WR*RAM_DATA_WIDTH-1:0]   w_data,
    output logic                               init_done
);

    localparam int AW = RAM_ADDR_WIDTH;
    localparam int DW = RAM_DATA_WIDTH;
    localparam int LW = lvt_width(NUM_WR);
    localparam int IW = lvt_width(RAM_DEPTH);
    localparam logic [AW:0]   DEPTH_X = (AW+1)'(RAM_DEPTH);
    localparam logic [IW-1:0] LAST    = IW'(RAM_DEPTH - 1);

    typedef logic [DW-1:0] data_t;

    state_e        state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic          ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = READY;
                    cnt_d   = '0;
                end
            end
            READY: ;
        endcase
    end

    assign ready     = (state_q == READY);
    assign init_done = ready;

    // Address decode; out-of-range and pre-sweep traffic is squashed here.
    logic [NUM_WR-1:0] wen;
    logic [IW-1:0]     w_idx [NUM_WR];
    data_t             w_dat [NUM_WR];
    logic [NUM_RD-1:0] r_ok;
    logic [IW-1:0]     r_idx [NUM_RD];

    always_comb begin
        for (int w = 0; w < NUM_WR; w++) begin
            wen[w]   = ready && w_val[w]
                       && ({1'b0, w_addr[w*AW +: AW]} < DEPTH_X);
            w_idx[w] = w_addr[w*AW +: IW];
            w_dat[w] = w_data[w*DW +: DW];
        end
        for (int r = 0; r < NUM_RD; r++) begin
            r_ok[r]  = ready && r_val[r]
                       && ({1'b0, r_addr[r*AW +: AW]} < DEPTH_X);
            r_idx[r] = r_addr[r*AW +: IW];
        end
    end

    // Bank write ports: the sweep owns them until READY.
    logic          b_we    [NUM_WR];
    logic [IW-1:0] b_waddr [NUM_WR];
    data_t         b_wdata [NUM_WR];

    always_comb begin
        for (int w = 0; w < NUM_WR; w++) begin
            b_we[w]    = ready ? wen[w]   : 1'b1;
            b_waddr[w] = ready ? w_idx[w] : cnt_q;
            b_wdata[w] = ready ? w_dat[w] : '0;
        end
    end

    // Ascending loop: the highest-index writer's update lands last.
    logic [LW-1:0] lvt [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (!ready) begin
            lvt[cnt_q] <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wen[w]) lvt[w_idx[w]] <= LW'(w);
            end
        end
    end

    // Same-cycle write hit per read port, highest port winning.
    logic  hit     [NUM_RD];
    data_t hit_dat [NUM_RD];

    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            hit[r]     = 1'b0;
            hit_dat[r] = '0;
            for (int w = 0; w < NUM_WR; w++) begin
                if (wen[w] && r_ok[r] && (w_idx[w] == r_idx[r])) begin
                    hit[r]     = 1'b1;
                    hit_dat[r] = w_dat[w];
                end
            end
        end
    end

    data_t bank_rd [NUM_WR][NUM_RD];

    for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
        for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
            ram_1w1r #(
                .RAM_TYPE   (RAM_TYPE),
                .RAM_DEPTH  (RAM_DEPTH),
                .IDX_WIDTH  (IW),
                .DATA_WIDTH (DW)
            ) u_bank (
                .clk   (clk),
                .we    (b_we[w]),
                .waddr (b_waddr[w]),
                .wdata (b_wdata[w]),
                .re    (r_ok[r]),
                .raddr (r_idx[r]),
                .rdata (bank_rd[w][r])
            );
        end
    end

    // Read-side steering captured alongside the bank read; all hold
    // while r_val is low so r_data holds too.
    logic [NUM_RD-1:0] zero_q;
    logic [NUM_RD-1:0] byp_q;
    data_t             byp_dat_q [NUM_RD];
    logic [LW-1:0]     sel_q     [NUM_RD];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= '1;
            byp_q  <= '0;
            for (int r = 0; r < NUM_RD; r++) begin
                byp_dat_q[r] <= '0;
                sel_q[r]     <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_RD; r++) begin
                if (r_val[r]) begin
                    zero_q[r]    <= !r_ok[r];
                    byp_q[r]     <= (WR_BYPASS != 0) && hit[r];
                    byp_dat_q[r] <= hit_dat[r];
                    sel_q[r]     <= lvt[r_idx[r]];
                end
            end
        end
    end

    always_comb begin
        r_data = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            if (zero_q[r])
                r_data[r*DW +: DW] = '0;
            else if (byp_q[r])
                r_data[r*DW +: DW] = byp_dat_q[r];
            else
                r_data[r*DW +: DW] = bank_rd[sel_q[r]][r];
        end
    end

endmodule

// File: tb/tb_ram_nwmr_lvt.sv
// Directed scoreboard bench for ram_nwmr_lvt; runs a bypass and a
// non-bypass instance side by side on identical stimulus.
module tb_ram_nwmr_lvt;

    localparam int AW    = 7;
    localparam int DW    = 32;
    localparam int NW    = 2;
    localparam int NR    = 4;
    localparam int DEPTH = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     r_val;
    logic [NR*AW-1:0]  r_addr;
    logic [NR*DW-1:0]  r_data_b, r_data_o;
    logic [NW-1:0]     w_val;
    logic [NW*AW-1:0]  w_addr;
    logic [NW*DW-1:0]  w_data;
    logic              done_b, done_o;

    always #5 clk = ~clk;

    ram_nwmr_lvt #(
        .RAM_TYPE(0), .RAM_DEPTH(DEPTH), .RAM_ADDR_WIDTH(AW),
        .RAM_DATA_WIDTH(DW), .NUM_WR(NW), .NUM_RD(NR), .WR_BYPASS(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .r_val(r_val), .r_addr(r_addr),
        .r_data(r_data_b), .w_val(w_val), .w_addr(w_addr),
        .w_data(w_data), .init_done(done_b)
    );

    ram_nwmr_lvt #(
        .RAM_TYPE(1), .RAM_DEPTH(DEPTH), .RAM_ADDR_WIDTH(AW),
        .RAM_DATA_WIDTH(DW), .NUM_WR(NW), .NUM_RD(NR), .WR_BYPASS(0)
    ) dut_o (
        .clk(clk), .rst_n(rst_n), .r_val(r_val), .r_addr(r_addr),
        .r_data(r_data_o), .w_val(w_val), .w_addr(w_addr),
        .w_data(w_data), .init_done(done_o)
    );

    typedef struct packed {
        logic [95:0] tag;
        logic [7:0]  port;
        logic [31:0] eb;
        logic [31:0] eo;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string dn, input logic [95:0] tag,
                         input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s %s observed=%h expected=%h", dn, tag, obs, exp);
        end
    endtask

    task automatic wr(input int p, input int a, input logic [31:0] d);
        w_val[p]          = 1'b1;
        w_addr[p*AW +: AW] = AW'(a);
        w_data[p*DW +: DW] = d;
    endtask

    task automatic rd(input int p, input int a, input logic [31:0] eb,
                      input logic [31:0] eo, input logic [95:0] tag);
        r_val[p]           = 1'b1;
        r_addr[p*AW +: AW] = AW'(a);
        sb.push_back('{tag: tag, port: 8'(p), eb: eb, eo: eo});
    endtask

    // One clock: launch what is driven, then score every queued read.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check("byp", e.tag, r_data_b[e.port*DW +: DW], e.eb);
            check("old", e.tag, r_data_o[e.port*DW +: DW], e.eo);
        end
        r_val = '0;
        w_val = '0;
    endtask

    task automatic check_cleared(input logic [95:0] tag);
        for (int p = 0; p < NR; p++) begin
            check("byp", tag, r_data_b[p*DW +: DW], 32'h0);
            check("old", tag, r_data_o[p*DW +: DW], 32'h0);
        end
        check("byp", "done_low", 32'(done_b), 32'h0);
        check("old", "done_low", 32'(done_o), 32'h0);
    endtask

    // Counts edges from release until init_done; bounded at 100.
    task automatic wait_init();
        int rise_b = 0;
        int rise_o = 0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (done_b && rise_b == 0) rise_b = k;
            if (done_o && rise_o == 0) rise_o = k;
            if (rise_b != 0 && rise_o != 0) break;
        end
        check("byp", "init_edge", 32'(rise_b), 32'd64);
        check("old", "init_edge", 32'(rise_o), 32'd64);
    endtask

    initial begin
        rst_n  = 1'b0;
        r_val  = '0;
        r_addr = '0;
        w_val  = '0;
        w_addr = '0;
        w_data = '0;

        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        rst_n = 1'b1;
        wait_init();

        for (int a = 0; a < DEPTH; a += NR) begin
            for (int p = 0; p < NR; p++) rd(p, a + p, 0, 0, "swept_zero");
            step();
        end

        wr(0, 5, 32'hAAAA_0001);
        step();
        wr(1, 5, 32'hBBBB_0002);
        step();
        for (int p = 0; p < NR; p++)
            rd(p, 5, 32'hBBBB_0002, 32'hBBBB_0002, "last_writer");
        step();

        wr(0, 9, 32'h11);
        wr(1, 9, 32'h22);
        step();
        for (int p = 0; p < NR; p++) rd(p, 9, 32'h22, 32'h22, "conflict");
        step();

        wr(0, 3, 32'h5);
        step();
        wr(1, 3, 32'h7);
        for (int p = 0; p < NR; p++) rd(p, 3, 32'h7, 32'h5, "rdw_same");
        step();
        for (int p = 0; p < NR; p++) rd(p, 3, 32'h7, 32'h7, "rdw_next");
        step();

        wr(0, 6, 32'h66);
        step();
        wr(1, 70, 32'hDEAD);
        rd(0, 70, 0, 0, "oor_rdw");
        step();
        rd(0, 70, 0, 0, "oor_read");
        rd(1, 6, 32'h66, 32'h66, "oor_alias");
        step();

        rd(2, 9, 32'h22, 32'h22, "pre_hold");
        step();
        r_addr[2*AW +: AW] = AW'(5);
        step();
        check("byp", "hold", r_data_b[2*DW +: DW], 32'h22);
        check("old", "hold", r_data_o[2*DW +: DW], 32'h22);

        wr(0, 2, 32'h1234);
        step();
        rd(0, 2, 32'h1234, 32'h1234, "pre_reset");
        step();

        // Reset lands between edges while a write and read are pending.
        wr(1, 2, 32'h5555);
        r_val[0]            = 1'b1;
        r_addr[0*AW +: AW]  = AW'(2);
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("async_clr");
        r_val = '0;
        w_val = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd(0, 2, 0, 0, "init_read");
        step();
        repeat (18) step();
        rst_n = 1'b0;
        #1;
        check_cleared("sweep_clr");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_init();

        for (int p = 0; p < NR; p++) rd(p, 2, 0, 0, "post_rst_a2");
        step();
        for (int p = 0; p < NR; p++) rd(p, 5, 0, 0, "post_rst_a5");
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
